// File: rtl/btn_bounce_gen_pkg.sv
// btn_pkg: shared FSM states, LFSR taps and counter sizing for btn_bounce_gen
//   macro BTN_BOUNCE_LFSR_EN selects randomized bounce timing in the top
package btn_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BOUNCE = 2'd1, SETTLE = 2'd2} state_t;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    // wide enough for a 1..16 random segment and the settle hold
    function automatic int cnt_w(input int ticks);
        return $clog2((ticks > 16 ? ticks : 16) + 1);
    endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR advancing once per enable strobe
//   clk, reset (async, high), en (shift strobe), seed (reset value, 0 -> 1), q (state)
module lfsr16
    import btn_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            q <= (seed == 16'h0) ? 16'h0001 : seed;
        else if (en)
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0);
endmodule

// File: rtl/btn_bounce_gen.sv
// btn_bounce_gen: turns a clean level request into a bouncing button waveform
//   clk, reset (async, high), en (timing strobe), req_press (requested level)
//   btn_out (bouncing line), busy (transition running), done (1-clk settled pulse)
//   macro BTN_BOUNCE_LFSR_EN: random glitch count and segment lengths from lfsr16
module btn_bounce_gen
    import btn_pkg::*;
#(
    parameter int          BOUNCE_EDGES = 2,
    parameter int          SEG_TICKS    = 3,
    parameter int          SETTLE_TICKS = 5,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_press,
    output logic btn_out,
    output logic busy,
    output logic done
);
    localparam int CW = cnt_w(SETTLE_TICKS > SEG_TICKS ? SETTLE_TICKS : SEG_TICKS);
    state_t          state, state_n;
    logic            btn_n, done_n;
    logic [3:0]      left, left_n;
    logic [CW-1:0]   tick, tick_n;
    logic [2:0]      g;
    logic [CW-1:0]   seg_len;
`ifdef BTN_BOUNCE_LFSR_EN
    logic [15:0] lfsr;
    lfsr16 u_lfsr (.clk(clk), .reset(reset), .en(en), .seed(LFSR_SEED), .q(lfsr));
    assign g       = (lfsr[6:4] > 3'(BOUNCE_EDGES)) ? 3'(BOUNCE_EDGES) : lfsr[6:4];
    assign seg_len = CW'(lfsr[3:0]) + CW'(1);
`else
    assign g       = 3'(BOUNCE_EDGES);
    assign seg_len = CW'(SEG_TICKS);
`endif
    assign busy = (state != IDLE);
    always_comb begin
        state_n = state;
        btn_n   = btn_out;
        left_n  = left;
        tick_n  = tick;
        done_n  = 1'b0;
        if (en)
            case (state)
                IDLE:
                    if (req_press != btn_out) begin
                        btn_n   = ~btn_out;
                        left_n  = {g, 1'b0};
                        state_n = (g != 3'd0) ? BOUNCE : SETTLE;
                        tick_n  = (g != 3'd0) ? seg_len : CW'(SETTLE_TICKS);
                    end
                BOUNCE:
                    if (tick == CW'(1)) begin
                        btn_n   = ~btn_out;
                        left_n  = left - 4'd1;
                        state_n = (left == 4'd1) ? SETTLE : BOUNCE;
                        tick_n  = (left == 4'd1) ? CW'(SETTLE_TICKS) : seg_len;
                    end else
                        tick_n = tick - CW'(1);
                SETTLE:
                    if (tick == CW'(1)) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                        tick_n  = '0;
                    end else
                        tick_n = tick - CW'(1);
                default:
                    state_n = IDLE;
            endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= IDLE;
            btn_out <= 1'b0;
            left    <= '0;
            tick    <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            btn_out <= btn_n;
            left    <= left_n;
            tick    <= tick_n;
            done    <= done_n;
        end
endmodule

// File: tb/tb_btn_bounce_gen.sv
// tb_btn_bounce_gen: self-checking bench for btn_bounce_gen (deterministic build)
module tb_btn_bounce_gen;
    localparam int G = 2, S = 3, ST = 5, D = 2 * G * S + ST;
    logic clk = 1'b0, reset = 1'b1, en = 1'b1, req = 1'b0, req0 = 1'b0;
    logic btn, busy, done, btn0, busy0, done0;
    int   n_cmp = 0, n_err = 0;

    btn_bounce_gen dut (.clk(clk), .reset(reset), .en(en), .req_press(req),
                        .btn_out(btn), .busy(busy), .done(done));
    btn_bounce_gen #(.BOUNCE_EDGES(0)) dut0 (.clk(clk), .reset(reset), .en(en), .req_press(req0),
                        .btn_out(btn0), .busy(busy0), .done(done0));

    always #5 clk = ~clk;

    // level after k en ticks of a transition starting from level s: toggles at ticks 0, sl, 2sl, ... 2g*sl
    function automatic logic lvl(input int k, input logic s, input int g, input int sl);
        int n;
        n = (k >= 2 * g * sl) ? 2 * g + 1 : k / sl + 1;
        return s ^ n[0];
    endfunction

    task automatic step(input logic e);
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [2:0] want;
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({btn, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_init got %b want 000", {btn, busy, done});
        end
        step(1'b1);
        reset = 1'b0;
        step(1'b1);
        req = 1'b1;
        step(1'b1);
        step(1'b1);
        want = 3'b110;
        n_cmp++;
        if ({btn, busy, done} !== want) begin
            n_err++;
            $display("FAIL reset_pre_bounce got %b want %b", {btn, busy, done}, want);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({btn, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid_bounce got %b want 000", {btn, busy, done});
        end
        req = 1'b0;
        step(1'b1);
        reset = 1'b0;
        step(1'b1);
    endtask

    task automatic test_press;
        logic [2:0] want;
        req = 1'b1;
        for (int t = 0; t <= 18; t++) begin
            step(1'b1);
            want = {lvl(t, 1'b0, G, S), t < D, t == D};
            n_cmp++;
            if ({btn, busy, done} !== want) begin
                n_err++;
                $display("FAIL press t=%0d got %b want %b", t, {btn, busy, done}, want);
            end
        end
    endtask

    task automatic test_release_ignored;
        logic [2:0] want;
        int k;
        req = 1'b0;
        for (int t = 0; t <= 36; t++) begin
            if (t == 4) req = 1'b1;
            step(1'b1);
            k = (t < 18) ? t : t - 18;
            want = {lvl(k, (t < 18), G, S), k < D, k == D};
            n_cmp++;
            if ({btn, busy, done} !== want) begin
                n_err++;
                $display("FAIL release t=%0d got %b want %b", t, {btn, busy, done}, want);
            end
        end
    endtask

    task automatic test_zero_edges;
        logic [2:0] want;
        req0 = 1'b1;
        for (int t = 0; t <= 6; t++) begin
            step(1'b1);
            want = {1'b1, t < ST, t == ST};
            n_cmp++;
            if ({btn0, busy0, done0} !== want) begin
                n_err++;
                $display("FAIL zero_edges t=%0d got %b want %b", t, {btn0, busy0, done0}, want);
            end
        end
    endtask

    task automatic test_enable_gating;
        logic [2:0] want;
        int k;
        req = 1'b0;
        for (int c = 0; c <= 72; c++) begin
            step(c % 4 == 0);
            k = c / 4;
            want = {lvl(k, 1'b1, G, S), k < D, c == 4 * D};
            n_cmp++;
            if ({btn, busy, done} !== want) begin
                n_err++;
                $display("FAIL gating c=%0d got %b want %b", c, {btn, busy, done}, want);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0] want;
        logic e, mlvl, s, active;
        int k;
        mlvl = btn === 1'b1;
        active = 1'b0;
        s = 1'b0;
        k = 0;
        for (int i = 0; i < 3000; i++) begin
            e = ($urandom % 4) != 0;
            if ($urandom % 16 == 0) req = ~req;
            step(e);
            if (e) begin
                if (active) k++;
                else if (req != mlvl) begin
                    active = 1'b1;
                    k = 0;
                    s = mlvl;
                end
            end
            if (active) mlvl = lvl(k, s, G, S);
            want = {mlvl, active && k < D, e && active && k == D};
            if (active && k >= D) active = 1'b0;
            n_cmp++;
            if ({btn, busy, done} !== want) begin
                n_err++;
                $display("FAIL random i=%0d got %b want %b", i, {btn, busy, done}, want);
            end
        end
    endtask

    initial begin
        test_reset;
        test_press;
        test_release_ignored;
        test_zero_edges;
        test_enable_gating;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
